// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and default width for the multiply/divide unit
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negation
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int W = MDU_WIDTH
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiply / restoring divide with Start/Busy/Done
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out_Hi,
    output logic [WIDTH-1:0] Out_Lo,
    output logic             Div_Zero
);

    state_e state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               is_div, neg_res, neg_rem, b_zero;
    logic [WIDTH-1:0]   a_orig, opnd, hi, lo;
    logic               sa, sb, load, step;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    // Op[0] marks the signed variants of both multiply and divide
    assign sa = Op[0] & In_A[WIDTH-1];
    assign sb = Op[0] & In_B[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH))   u_a_mag (.value(In_A), .neg(sa), .result(a_mag));
    mdu_sign_fix #(.W(WIDTH))   u_b_mag (.value(In_B), .neg(sb), .result(b_mag));
    mdu_sign_fix #(.W(2*WIDTH)) u_prod  (.value({hi, lo}), .neg(neg_res), .result(prod_fix));
    mdu_sign_fix #(.W(WIDTH))   u_quo   (.value(lo), .neg(neg_res), .result(quo_fix));
    mdu_sign_fix #(.W(WIDTH))   u_rem   (.value(hi), .neg(neg_rem), .result(rem_fix));

    assign mul_sum   = {1'b0, hi} + {1'b0, opnd};
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            S_IDLE: if (Start) begin
                load      = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                Busy = 1'b1;
                step = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = S_FIN;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Multiply keeps the multiplier in lo and adds the multiplicand into hi;
    // divide keeps the dividend/quotient in lo and the partial remainder in hi.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            a_orig   <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            Done     <= 1'b0;
            Out_Hi   <= '0;
            Out_Lo   <= '0;
            Div_Zero <= 1'b0;
        end else begin
            Done <= (state == S_FIN);
            if (load) begin
                cnt     <= CNT_W'(WIDTH);
                is_div  <= Op[1];
                neg_res <= sa ^ sb;
                neg_rem <= sa;
                b_zero  <= (In_B == '0);
                a_orig  <= In_A;
                opnd    <= Op[1] ? b_mag : a_mag;
                hi      <= '0;
                lo      <= Op[1] ? a_mag : b_mag;
            end
            if (step) begin
                cnt <= cnt - CNT_W'(1);
                if (is_div) begin
                    if (!div_diff[WIDTH]) begin
                        hi <= div_diff[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi <= div_shift[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], 1'b0};
                    end
                end else if (lo[0]) begin
                    {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                end else begin
                    {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
                end
            end
            if (state == S_FIN) begin
                if (!is_div) begin
                    {Out_Hi, Out_Lo} <= prod_fix;
                    Div_Zero         <= 1'b0;
                end else if (b_zero) begin
                    Out_Hi   <= a_orig;
                    Out_Lo   <= '1;
                    Div_Zero <= 1'b1;
                end else begin
                    Out_Hi   <= rem_fix;
                    Out_Lo   <= quo_fix;
                    Div_Zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] In_A = '0;
    logic [31:0] In_B = '0;
    logic        Busy, Done, Div_Zero;
    logic [31:0] Out_Hi, Out_Lo;

    int total = 0;
    int bad = 0;

    mul_div_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .In_A(In_A), .In_B(In_B),
        .Busy(Busy), .Done(Done), .Out_Hi(Out_Hi), .Out_Lo(Out_Lo), .Div_Zero(Div_Zero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        if (op == 2'b00) begin
            p = {32'b0, a} * {32'b0, b};
            {hi, lo} = p;
        end else if (op == 2'b01) begin
            p = 64'(sa * sb);
            {hi, lo} = p;
        end else if (b == 32'd0) begin
            dz = 1'b1;
            lo = '1;
            hi = a;
        end else if (op == 2'b10) begin
            lo = a / b;
            hi = a % b;
        end else begin
            q = sa / sb;
            r = sa % sb;
            lo = 32'(q);
            hi = 32'(r);
        end
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, input logic [31:0] prev_lo,
                          output int lat, output int busy_n);
        @(negedge Clk);
        Start = 1'b1; Op = op; In_A = a; In_B = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!Done && lat < 80) begin
            if (Busy) busy_n++;
            if (poke) begin
                Start = (lat == 5 || lat == 32);
                Op    = 2'($urandom_range(0, 3));
                In_A  = $urandom;
                In_B  = $urandom;
                if (lat == 10) chk("hold_during_run", Out_Lo, prev_lo);
            end
            @(posedge Clk); #1;
            lat++;
        end
        Start = 1'b0;
    endtask

    initial begin
        int lat, busy_n, seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb, ehi, elo;
        logic        edz;

        tbl[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[4] = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
        tbl[5] = '{2'b00, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        tbl[6] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[7] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        tbl[8] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_hi", Out_Hi, 0);
        chk("rst_lo", Out_Lo, 0);
        chk("rst_dz", Div_Zero, 0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, '0, lat, busy_n);
            chk($sformatf("vec%0d_lat", i), lat, 33);
            chk($sformatf("vec%0d_busy", i), busy_n, 32);
            chk($sformatf("vec%0d_hi", i), Out_Hi, tbl[i].hi);
            chk($sformatf("vec%0d_lo", i), Out_Lo, tbl[i].lo);
            chk($sformatf("vec%0d_dz", i), Div_Zero, tbl[i].dz);
        end

        // overflow divide with Start re-pulsed mid-RUN and during FIN
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, tbl[8].lo, lat, busy_n);
        chk("poke_lat", lat, 33);
        chk("poke_hi", Out_Hi, 32'h0);
        chk("poke_lo", Out_Lo, 32'h80000000);
        chk("poke_dz", Div_Zero, 0);
        @(posedge Clk); #1;
        chk("fin_start_ignored", Busy, 0);

        // reset in the middle of a multiply
        @(negedge Clk);
        Start = 1'b1; Op = 2'b00; In_A = '1; In_B = '1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_hi", Out_Hi, 0);
        chk("abort_lo", Out_Lo, 0);
        chk("abort_dz", Div_Zero, 0);
        @(negedge Clk);
        Reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Done || Busy) seen = 1;
        end
        chk("abort_quiet", seen, 0);
        run_op(2'b00, 32'd2, 32'd3, 1'b0, '0, lat, busy_n);
        chk("after_abort_lat", lat, 33);
        chk("after_abort_lo", Out_Lo, 32'd6);
        chk("after_abort_hi", Out_Hi, 32'd0);

        for (int n = 0; n < 150; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, ehi, elo, edz);
            run_op(rop, ra, rb, 1'b0, '0, lat, busy_n);
            chk($sformatf("rnd%0d_lat op=%0d a=%h b=%h", n, rop, ra, rb), lat, 33);
            chk($sformatf("rnd%0d_hi op=%0d a=%h b=%h", n, rop, ra, rb), Out_Hi, ehi);
            chk($sformatf("rnd%0d_lo op=%0d a=%h b=%h", n, rop, ra, rb), Out_Lo, elo);
            chk($sformatf("rnd%0d_dz op=%0d a=%h b=%h", n, rop, ra, rb), Div_Zero, edz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
